sc_readback_rx: RTL and testbench

Receiver end of the MAROC slow-control serial chain. It samples the chip's shift-register output, which carries the frame shifted in by the transmitter, 829 bits LSB first. It reassembles the frame into a parallel word and checks it bit by bit against the expected configuration. The result gives a pass/fail and error count to the control FPGA logic for configuration verification.

---
 rtl/sc_pkg.sv | 24 ++
 rtl/sc_readback_rx_if.sv | 42 ++++
 rtl/sc_bit_checker.sv | 54 +++++
 rtl/sc_readback_rx.sv | 119 +++++++++++
 tb/tb_sc_readback_rx.sv | 347 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sc_pkg.sv
// Shared definitions for the MAROC slow-control readback receiver: frame size,
// counter width, frame field offsets and the receiver state encoding.
package sc_pkg;

    localparam int SC_FRAME_BITS = 829;
    localparam int SC_CNT_W      = 10;

    localparam logic [SC_CNT_W-1:0] SC_LAST_IDX = SC_CNT_W'(SC_FRAME_BITS - 1);

    // Bit offsets of the main fields inside the 829-bit frame (LSB first)
    localparam int SC_OFS_DAC2       = 3;
    localparam int SC_OFS_DAC1       = 13;
    localparam int SC_OFS_MASK_OR    = 27;
    localparam int SC_OFS_GLOBAL_CFG = 155;
    localparam int SC_OFS_GAIN       = 189;
    localparam int SC_OFS_CTEST      = 765;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } sc_state_t;

endpackage

// File: rtl/sc_readback_rx_if.sv
// Bus bundle between the slow-control readback receiver and its user.
// Optional first-error reporting signals exist only under SC_RX_FIRST_ERR_EN.
interface sc_readback_rx_if;
    import sc_pkg::*;

    logic                     arm;
    logic                     Q_SC;
    logic [SC_FRAME_BITS-1:0] expected;
    logic [SC_FRAME_BITS-1:0] rx_word;
    logic                     rx_valid;
    logic                     mismatch;
    logic [SC_CNT_W-1:0]      err_cnt;
    logic                     busy;
    logic [SC_CNT_W-1:0]      bit_idx;
`ifdef SC_RX_FIRST_ERR_EN
    logic [SC_CNT_W-1:0]      first_err_idx;
    logic                     err_seen;

    modport master (
        output arm, Q_SC, expected,
        input  rx_word, rx_valid, mismatch, err_cnt, busy, bit_idx,
               first_err_idx, err_seen
    );

    modport slave (
        input  arm, Q_SC, expected,
        output rx_word, rx_valid, mismatch, err_cnt, busy, bit_idx,
               first_err_idx, err_seen
    );
`else
    modport master (
        output arm, Q_SC, expected,
        input  rx_word, rx_valid, mismatch, err_cnt, busy, bit_idx
    );

    modport slave (
        input  arm, Q_SC, expected,
        output rx_word, rx_valid, mismatch, err_cnt, busy, bit_idx
    );
`endif

endinterface

// File: rtl/sc_bit_checker.sv
// Per-bit compare of the incoming serial stream against the reference frame.
// Keeps the running error count; SC_RX_FIRST_ERR_EN adds first-error tracking.
module sc_bit_checker
    import sc_pkg::*;
(
    input  logic                     CK_SC,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     en,
    input  logic                     sample,
    input  logic [SC_FRAME_BITS-1:0] expected,
    input  logic [SC_CNT_W-1:0]      idx,
`ifdef SC_RX_FIRST_ERR_EN
    output logic [SC_CNT_W-1:0]      run_first,
    output logic                     run_seen,
`endif
    output logic [SC_CNT_W-1:0]      run_cnt
);

    logic                diff;
    logic [SC_CNT_W-1:0] cnt_q;
`ifdef SC_RX_FIRST_ERR_EN
    logic [SC_CNT_W-1:0] first_q;
    logic                seen_q;
`endif

    assign diff = sample ^ expected[idx];

    // Count cannot pass SC_FRAME_BITS, which fits in SC_CNT_W bits, so no saturation
    always_ff @(posedge CK_SC) begin
        if (!rst || clear) begin
            cnt_q   <= '0;
`ifdef SC_RX_FIRST_ERR_EN
            first_q <= '0;
            seen_q  <= 1'b0;
`endif
        end else if (en && diff) begin
            cnt_q <= cnt_q + SC_CNT_W'(1);
`ifdef SC_RX_FIRST_ERR_EN
            if (!seen_q) begin
                first_q <= idx;
                seen_q  <= 1'b1;
            end
`endif
        end
    end

    assign run_cnt   = cnt_q;
`ifdef SC_RX_FIRST_ERR_EN
    assign run_first = first_q;
    assign run_seen  = seen_q;
`endif

endmodule

// File: rtl/sc_readback_rx.sv
// MAROC slow-control readback receiver: captures an 829-bit LSB-first frame and
// compares it to the reference. Optional macro SC_RX_FIRST_ERR_EN adds first-error reporting.
//
//  state | meaning
//  IDLE  | waiting for arm; bit_idx held at 0
//  SHIFT | sampling Q_SC on every edge, bit_idx counts up to FRAME_BITS-1
//  DONE  | one cycle: publish rx_word / err_cnt / mismatch and pulse rx_valid
module sc_readback_rx
    import sc_pkg::*;
(
    input  logic            CK_SC,
    input  logic            rst,
    sc_readback_rx_if.slave bus
);

    sc_state_t                state_q, state_d;
    logic [SC_FRAME_BITS-1:0] shreg_q;
    logic [SC_CNT_W-1:0]      idx_q;
    logic [SC_FRAME_BITS-1:0] rx_word_q;
    logic [SC_CNT_W-1:0]      err_cnt_q;
    logic                     mismatch_q;
    logic                     rx_valid_q;
    logic [SC_CNT_W-1:0]      run_cnt;
    logic                     start;
    logic                     shift_en;
    logic                     last_bit;
`ifdef SC_RX_FIRST_ERR_EN
    logic [SC_CNT_W-1:0]      run_first;
    logic                     run_seen;
    logic [SC_CNT_W-1:0]      first_err_q;
    logic                     err_seen_q;
`endif

    assign last_bit = (idx_q == SC_LAST_IDX);

    always_comb begin
        state_d  = state_q;
        start    = 1'b0;
        shift_en = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.arm) begin
                    start   = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                shift_en = 1'b1;
                if (last_bit) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CK_SC) begin
        if (!rst) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            idx_q       <= '0;
            rx_word_q   <= '0;
            err_cnt_q   <= '0;
            mismatch_q  <= 1'b0;
            rx_valid_q  <= 1'b0;
`ifdef SC_RX_FIRST_ERR_EN
            first_err_q <= '0;
            err_seen_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            rx_valid_q <= 1'b0;
            if (start) begin
                shreg_q <= '0;
                idx_q   <= '0;
            end else if (shift_en) begin
                shreg_q <= {bus.Q_SC, shreg_q[SC_FRAME_BITS-1:1]};
                idx_q   <= last_bit ? '0 : idx_q + SC_CNT_W'(1);
            end
            // Results are registered on the DONE edge so rx_valid and the data appear together
            if (state_q == DONE) begin
                rx_word_q   <= shreg_q;
                err_cnt_q   <= run_cnt;
                mismatch_q  <= (run_cnt != '0);
                rx_valid_q  <= 1'b1;
`ifdef SC_RX_FIRST_ERR_EN
                first_err_q <= run_first;
                err_seen_q  <= run_seen;
`endif
            end
        end
    end

    sc_bit_checker u_checker (
        .CK_SC     (CK_SC),
        .rst       (rst),
        .clear     (start),
        .en        (shift_en),
        .sample    (bus.Q_SC),
        .expected  (bus.expected),
        .idx       (idx_q),
`ifdef SC_RX_FIRST_ERR_EN
        .run_first (run_first),
        .run_seen  (run_seen),
`endif
        .run_cnt   (run_cnt)
    );

    assign bus.rx_word  = rx_word_q;
    assign bus.rx_valid = rx_valid_q;
    assign bus.mismatch = mismatch_q;
    assign bus.err_cnt  = err_cnt_q;
    assign bus.busy     = (state_q != IDLE);
    assign bus.bit_idx  = idx_q;
`ifdef SC_RX_FIRST_ERR_EN
    assign bus.first_err_idx = first_err_q;
    assign bus.err_seen      = err_seen_q;
`endif

endmodule

// File: tb/tb_sc_readback_rx.sv
// Self-checking bench for sc_readback_rx: random frames against a frame-level
// reference model (XOR popcount / first differing bit).
module tb_sc_readback_rx;
    localparam int F  = sc_pkg::SC_FRAME_BITS;
    localparam int CW = sc_pkg::SC_CNT_W;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   arm_cyc = 0;

    int             v_cyc[$];
    logic [F-1:0]   v_word[$];
    logic [CW-1:0]  v_err[$];
    logic           v_mis[$];
`ifdef SC_RX_FIRST_ERR_EN
    logic [CW-1:0]  v_first[$];
    logic           v_seen[$];
`endif

    sc_readback_rx_if bus();

    sc_readback_rx dut (
        .CK_SC (clk),
        .rst   (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.rx_valid === 1'b1) begin
            v_cyc.push_back(cyc);
            v_word.push_back(bus.rx_word);
            v_err.push_back(bus.err_cnt);
            v_mis.push_back(bus.mismatch);
`ifdef SC_RX_FIRST_ERR_EN
            v_first.push_back(bus.first_err_idx);
            v_seen.push_back(bus.err_seen);
`endif
        end
    end

    function automatic logic [F-1:0] rand_vec();
        logic [F-1:0] v;
        for (int i = 0; i < F; i++) v[i] = 1'($urandom_range(0, 1));
        return v;
    endfunction

    function automatic int ref_err(input logic [F-1:0] a, input logic [F-1:0] b);
        return $countones(a ^ b);
    endfunction

    function automatic int ref_first(input logic [F-1:0] a, input logic [F-1:0] b);
        for (int i = 0; i < F; i++) if (a[i] != b[i]) return i;
        return 0;
    endfunction

    // Arms a capture and serialises 'sent' LSB first on negedges.
    task automatic drive_frame(input logic [F-1:0] sent, input logic [F-1:0] exp,
                               input int glitch_idx, input int rst_idx, input bit arm_now);
        if (!arm_now) @(negedge clk);
        bus.expected = exp;
        bus.arm = 1'b1;
        @(negedge clk);
        arm_cyc = cyc;
        for (int k = 0; k < F; k++) begin
            if (k > 0) @(negedge clk);
            if (k == 300) begin
                total++;
                if (bus.bit_idx !== 10'd300 || bus.busy !== 1'b1) begin
                    bad++;
                    $display("FAIL shift_progress: bit_idx=%0d busy=%b want 300/1", bus.bit_idx, bus.busy);
                end
            end
            if (k == rst_idx) begin
                bus.arm = 1'b0;
                rst_n = 1'b0;
                return;
            end
            bus.Q_SC = sent[k];
            bus.arm = (k == glitch_idx);
        end
    endtask

    task automatic wait_valid(input int s0, output bit got);
        got = 1'b0;
        for (int i = 0; i < 1000 && !got; i++) begin
            @(negedge clk);
            #1;
            if (v_cyc.size() > s0) got = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.arm = 1'b0;
        bus.Q_SC = 1'b0;
        bus.expected = '0;
        repeat (3) @(negedge clk);
        total++;
        if (bus.rx_valid !== 1'b0 || bus.mismatch !== 1'b0 || bus.err_cnt !== '0) begin
            bad++;
            $display("FAIL reset_flags: rx_valid=%b mismatch=%b err_cnt=%0d want 0", bus.rx_valid, bus.mismatch, bus.err_cnt);
        end
        total++;
        if (bus.busy !== 1'b0 || bus.bit_idx !== '0 || bus.rx_word !== '0) begin
            bad++;
            $display("FAIL reset_state: busy=%b bit_idx=%0d rx_word_nonzero=%b want 0", bus.busy, bus.bit_idx, |bus.rx_word);
        end
`ifdef SC_RX_FIRST_ERR_EN
        total++;
        if (bus.first_err_idx !== '0 || bus.err_seen !== 1'b0) begin
            bad++;
            $display("FAIL reset_first: first_err_idx=%0d err_seen=%b want 0", bus.first_err_idx, bus.err_seen);
        end
`endif
        bus.arm = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        bus.arm = 1'b0;
        @(negedge clk);
        total++;
        if (bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_arm_priority: busy=%b want 0", bus.busy);
        end
    endtask

    task automatic test_match();
        logic [F-1:0] pat;
        int s0;
        bit got;
        for (int i = 0; i < F; i++) pat[i] = ~i[0];
        s0 = v_cyc.size();
        drive_frame(pat, pat, -1, -1, 1'b0);
        wait_valid(s0, got);
        total++;
        if (!got) begin
            bad++;
            $display("FAIL match_valid: no rx_valid seen, want one");
        end else begin
            total++;
            if (v_cyc[s0] - arm_cyc !== 830) begin
                bad++;
                $display("FAIL match_latency: got %0d want 830", v_cyc[s0] - arm_cyc);
            end
            total++;
            if (v_word[s0] !== pat) begin
                bad++;
                $display("FAIL match_word: got %h want %h", v_word[s0], pat);
            end
            total++;
            if (v_mis[s0] !== 1'b0 || v_err[s0] !== '0) begin
                bad++;
                $display("FAIL match_errs: mismatch=%b err_cnt=%0d want 0/0", v_mis[s0], v_err[s0]);
            end
            repeat (5) @(negedge clk);
            total++;
            if (bus.rx_word !== pat || bus.rx_valid !== 1'b0 || bus.busy !== 1'b0 || v_cyc.size() != s0 + 1) begin
                bad++;
                $display("FAIL match_hold: rx_valid=%b busy=%b word_ok=%b pulses=%0d want 0/0/1/1",
                         bus.rx_valid, bus.busy, bus.rx_word === pat, v_cyc.size() - s0);
            end
        end
    endtask

    task automatic test_patterns();
        logic [F-1:0] exp, sent;
        int s0, n;
        bit got;
        for (int c = 0; c < 6; c++) begin
            exp = rand_vec();
            sent = exp;
            case (c)
                0: begin
                    sent[0] = ~sent[0];
                    sent[400] = ~sent[400];
                    sent[828] = ~sent[828];
                end
                1: begin
                    exp = '0;
                    sent = '1;
                end
                2: ;
                default: begin
                    n = $urandom_range(1, 60);
                    for (int j = 0; j < n; j++) sent[$urandom_range(0, F - 1)] ^= 1'b1;
                end
            endcase
            s0 = v_cyc.size();
            drive_frame(sent, exp, -1, -1, 1'b0);
            wait_valid(s0, got);
            total++;
            if (!got) begin
                bad++;
                $display("FAIL pat%0d_valid: no rx_valid seen, want one", c);
            end else begin
                total++;
                if (v_cyc[s0] - arm_cyc !== 830) begin
                    bad++;
                    $display("FAIL pat%0d_latency: got %0d want 830", c, v_cyc[s0] - arm_cyc);
                end
                total++;
                if (v_word[s0] !== sent) begin
                    bad++;
                    $display("FAIL pat%0d_word: got %h want %h", c, v_word[s0], sent);
                end
                total++;
                if (v_err[s0] !== CW'(ref_err(sent, exp)) || v_mis[s0] !== (ref_err(sent, exp) != 0)) begin
                    bad++;
                    $display("FAIL pat%0d_errs: err_cnt=%0d mismatch=%b want %0d/%b",
                             c, v_err[s0], v_mis[s0], ref_err(sent, exp), ref_err(sent, exp) != 0);
                end
`ifdef SC_RX_FIRST_ERR_EN
                total++;
                if (v_first[s0] !== CW'(ref_first(sent, exp)) || v_seen[s0] !== (ref_err(sent, exp) != 0)) begin
                    bad++;
                    $display("FAIL pat%0d_first: first_err_idx=%0d err_seen=%b want %0d/%b",
                             c, v_first[s0], v_seen[s0], ref_first(sent, exp), ref_err(sent, exp) != 0);
                end
`endif
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [F-1:0] exp, sent;
        int s0;
        bit got;
        exp = rand_vec();
        sent = rand_vec();
        s0 = v_cyc.size();
        drive_frame(sent, exp, -1, 500, 1'b0);
        @(negedge clk);
        total++;
        if (bus.rx_word !== '0 || bus.err_cnt !== '0 || bus.busy !== 1'b0 || bus.mismatch !== 1'b0) begin
            bad++;
            $display("FAIL midrst_clear: word_nonzero=%b err_cnt=%0d busy=%b mismatch=%b want 0",
                     |bus.rx_word, bus.err_cnt, bus.busy, bus.mismatch);
        end
        rst_n = 1'b1;
        repeat (400) @(negedge clk);
        total++;
        if (v_cyc.size() != s0) begin
            bad++;
            $display("FAIL midrst_novalid: pulses=%0d want 0", v_cyc.size() - s0);
        end
        drive_frame(sent, exp, -1, -1, 1'b0);
        wait_valid(s0, got);
        total++;
        if (!got) begin
            bad++;
            $display("FAIL midrst_rearm_valid: no rx_valid seen, want one");
        end else begin
            total++;
            if (v_word[s0] !== sent || v_err[s0] !== CW'(ref_err(sent, exp)) || v_cyc[s0] - arm_cyc !== 830) begin
                bad++;
                $display("FAIL midrst_rearm: word_ok=%b err_cnt=%0d latency=%0d want 1/%0d/830",
                         v_word[s0] === sent, v_err[s0], v_cyc[s0] - arm_cyc, ref_err(sent, exp));
            end
        end
    endtask

    task automatic test_arm_ignored();
        logic [F-1:0] exp, sent;
        int s0;
        bit got;
        exp = rand_vec();
        sent = rand_vec();
        s0 = v_cyc.size();
        drive_frame(sent, exp, 100, -1, 1'b0);
        wait_valid(s0, got);
        repeat (900) @(negedge clk);
        total++;
        if (!got || v_cyc.size() != s0 + 1) begin
            bad++;
            $display("FAIL armign_count: pulses=%0d want 1", v_cyc.size() - s0);
        end else begin
            total++;
            if (v_cyc[s0] - arm_cyc !== 830 || v_word[s0] !== sent || v_err[s0] !== CW'(ref_err(sent, exp))) begin
                bad++;
                $display("FAIL armign_result: latency=%0d word_ok=%b err_cnt=%0d want 830/1/%0d",
                         v_cyc[s0] - arm_cyc, v_word[s0] === sent, v_err[s0], ref_err(sent, exp));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [F-1:0] exp_a, sent_a, exp_b, sent_b;
        int s0;
        bit got_a, got_b;
        exp_a = rand_vec();
        sent_a = rand_vec();
        exp_b = rand_vec();
        sent_b = ~sent_a;
        s0 = v_cyc.size();
        drive_frame(sent_a, exp_a, -1, -1, 1'b0);
        wait_valid(s0, got_a);
        drive_frame(sent_b, exp_b, -1, -1, 1'b1);
        wait_valid(s0 + 1, got_b);
        total++;
        if (!got_a || !got_b) begin
            bad++;
            $display("FAIL b2b_valid: got pulses=%0d want 2", v_cyc.size() - s0);
        end else begin
            total++;
            if (v_cyc[s0 + 1] - v_cyc[s0] !== 831) begin
                bad++;
                $display("FAIL b2b_spacing: got %0d want 831", v_cyc[s0 + 1] - v_cyc[s0]);
            end
            total++;
            if (v_word[s0] !== sent_a || v_err[s0] !== CW'(ref_err(sent_a, exp_a))) begin
                bad++;
                $display("FAIL b2b_first: word_ok=%b err_cnt=%0d want 1/%0d",
                         v_word[s0] === sent_a, v_err[s0], ref_err(sent_a, exp_a));
            end
            total++;
            if (v_word[s0 + 1] !== sent_b || v_err[s0 + 1] !== CW'(ref_err(sent_b, exp_b))) begin
                bad++;
                $display("FAIL b2b_second: word_ok=%b err_cnt=%0d want 1/%0d",
                         v_word[s0 + 1] === sent_b, v_err[s0 + 1], ref_err(sent_b, exp_b));
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_match();
        test_patterns();
        test_reset_mid();
        test_arm_ignored();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
